// File: rtl/ddr_cmd_pkg.sv
// Shared DDR command encodings and sequencer state type for the bank sequencer slice.
package ddr_cmd_pkg;

   // Command pins are {RAS, CAS, WE}, all active low.
   typedef enum logic [2:0] {
      CMD_NOOP = 3'b111,
      CMD_ACTV = 3'b011,
      CMD_READ = 3'b101,
      CMD_WRTE = 3'b100,
      CMD_PRCH = 3'b010,
      CMD_ARSR = 3'b001
   } ddr_cmd_e;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_DECODE   = 3'd1,
      ST_PRCH     = 3'd2,
      ST_ACTV     = 3'd3,
      ST_REF_PRCH = 3'd4,
      ST_REF_ARSR = 3'd5
   } seq_state_e;

   localparam int unsigned A10_BIT = 10;

endpackage

// File: rtl/ddr_row_table.sv
// Per-bank open-row bookkeeping: open flag plus the row latched by the last ACTV to that bank.
module ddr_row_table
   import ddr_cmd_pkg::*;
#(
   parameter int unsigned ROW_W  = 13,
   parameter int unsigned BANK_W = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [BANK_W-1:0] lookup_bank_i,
   input  logic [ROW_W-1:0]  lookup_row_i,
   output logic              hit_o,
   output logic              closed_o,
   input  logic              set_i,
   input  logic [BANK_W-1:0] set_bank_i,
   input  logic [ROW_W-1:0]  set_row_i,
   input  logic              clr_one_i,
   input  logic [BANK_W-1:0] clr_bank_i,
   input  logic              clr_all_i,
   output logic              any_open_o
);

   localparam int unsigned NUM_BANKS = 2 ** BANK_W;

   logic [NUM_BANKS-1:0] open_q;
   logic [ROW_W-1:0]     row_q [NUM_BANKS];

   // Open flags and row registers; a clear always outranks a set in the same cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         open_q <= {NUM_BANKS{1'b0}};
         for (int i = 0; i < NUM_BANKS; i++) begin
            row_q[i] <= {ROW_W{1'b0}};
         end
      end else if (clr_all_i) begin
         open_q <= {NUM_BANKS{1'b0}};
      end else if (clr_one_i) begin
         open_q[clr_bank_i] <= 1'b0;
      end else if (set_i) begin
         open_q[set_bank_i] <= 1'b1;
         row_q[set_bank_i]  <= set_row_i;
      end
   end

   assign closed_o   = ~open_q[lookup_bank_i];
   assign hit_o      = open_q[lookup_bank_i] & (row_q[lookup_bank_i] == lookup_row_i);
   assign any_open_o = |open_q;

endmodule

// File: rtl/ddr_bank_sequencer.sv
// DDR SDRAM command sequencer: open-row tracking per bank, one request at a time,
// programmable tRP/tRCD/tRFC and toggle-style refresh; command/address pins are registered.
module ddr_bank_sequencer
   import ddr_cmd_pkg::*;
#(
   parameter int unsigned ROW_W       = 13,
   parameter int unsigned COL_W       = 10,
   parameter int unsigned BANK_W      = 2,
   parameter int unsigned T_RP        = 3,
   parameter int unsigned T_RCD       = 3,
   parameter int unsigned T_RFC       = 10,
   parameter int unsigned CAS_LATENCY = 3,
   parameter int unsigned CNT_W       = 4
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          refresh_strobe_i,
   input  logic                          req_valid_i,
   output logic                          req_ready_o,
   input  logic                          req_we_i,
   input  logic [ROW_W+BANK_W+COL_W-1:0] req_addr_i,
   output logic [2:0]                    cmd_o,
   output logic [ROW_W-1:0]              addr_o,
   output logic [BANK_W-1:0]             bank_o,
   output logic                          wr_en_o,
   output logic                          rd_valid_o,
   output logic                          any_row_open_o
);

   localparam int unsigned AW = ROW_W + BANK_W + COL_W;
   // Counters load T-1 so the next command lands exactly T cycles after the previous one.
   localparam logic [CNT_W-1:0] RP_LD  = CNT_W'(T_RP - 1);
   localparam logic [CNT_W-1:0] RCD_LD = CNT_W'(T_RCD - 1);
   localparam logic [CNT_W-1:0] RFC_LD = CNT_W'(T_RFC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   seq_state_e              state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   ddr_cmd_e                cmd_q, cmd_d;
   logic [ROW_W-1:0]        addr_q, addr_d;
   logic [BANK_W-1:0]       bank_q, bank_d;
   logic                    ack_q, ack_d;
   logic                    wr_en_q;
   logic [CAS_LATENCY-1:0]  rd_pipe_q;
   logic                    req_we_q;
   logic [AW-1:0]           req_addr_q;

   logic                    refresh_pending_s;
   logic                    hit_s, closed_s, any_open_s;
   logic                    set_s, clr_one_s, clr_all_s;
   logic                    go_actv_s, go_rw_s;
   logic [ROW_W-1:0]        req_row_s;
   logic [BANK_W-1:0]       req_bank_s;
   logic [ROW_W-1:0]        rw_addr_s;

   assign req_row_s         = req_addr_q[AW-1 -: ROW_W];
   assign req_bank_s        = req_addr_q[COL_W +: BANK_W];
   assign refresh_pending_s = refresh_strobe_i ^ ack_q;
   assign req_ready_o       = (state_q == ST_IDLE) & ~refresh_pending_s & ~rst_i;

   ddr_row_table #(
      .ROW_W  (ROW_W),
      .BANK_W (BANK_W)
   ) u_row_table (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .lookup_bank_i (req_bank_s),
      .lookup_row_i  (req_row_s),
      .hit_o         (hit_s),
      .closed_o      (closed_s),
      .set_i         (set_s),
      .set_bank_i    (req_bank_s),
      .set_row_i     (req_row_s),
      .clr_one_i     (clr_one_s),
      .clr_bank_i    (req_bank_s),
      .clr_all_i     (clr_all_s),
      .any_open_o    (any_open_s)
   );

   // Column address, zero-extended, with A10 low so READ/WRTE never auto-precharge.
   always_comb begin
      rw_addr_s              = {ROW_W{1'b0}};
      rw_addr_s[COL_W-1:0]   = req_addr_q[COL_W-1:0];
      rw_addr_s[A10_BIT]     = 1'b0;
   end

   // Next-state and command decode.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cmd_d     = CMD_NOOP;
      addr_d    = addr_q;
      bank_d    = bank_q;
      ack_d     = ack_q;
      set_s     = 1'b0;
      clr_one_s = 1'b0;
      clr_all_s = 1'b0;
      go_actv_s = 1'b0;
      go_rw_s   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (refresh_pending_s) begin
               if (any_open_s) begin
                  cmd_d           = CMD_PRCH;
                  addr_d          = {ROW_W{1'b0}};
                  addr_d[A10_BIT] = 1'b1;
                  bank_d          = {BANK_W{1'b0}};
                  clr_all_s       = 1'b1;
                  cnt_d           = RP_LD;
                  state_d         = ST_REF_PRCH;
               end else begin
                  cmd_d   = CMD_ARSR;
                  ack_d   = refresh_strobe_i;
                  cnt_d   = RFC_LD;
                  state_d = ST_REF_ARSR;
               end
            end else if (req_valid_i) begin
               state_d = ST_DECODE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DECODE: begin
            if (hit_s) begin
               go_rw_s = 1'b1;
            end else if (closed_s) begin
               go_actv_s = 1'b1;
            end else begin
               cmd_d     = CMD_PRCH;
               addr_d    = {ROW_W{1'b0}};
               bank_d    = req_bank_s;
               clr_one_s = 1'b1;
               cnt_d     = RP_LD;
               state_d   = ST_PRCH;
            end
         end
         ST_PRCH: begin
            if (cnt_q == {CNT_W{1'b0}}) begin
               go_actv_s = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_ACTV: begin
            if (cnt_q == {CNT_W{1'b0}}) begin
               go_rw_s = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_REF_PRCH: begin
            if (cnt_q == {CNT_W{1'b0}}) begin
               cmd_d   = CMD_ARSR;
               ack_d   = refresh_strobe_i;
               cnt_d   = RFC_LD;
               state_d = ST_REF_ARSR;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_REF_ARSR: begin
            if (cnt_q == {CNT_W{1'b0}}) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      case ({go_actv_s, go_rw_s})
         2'b10: begin
            cmd_d   = CMD_ACTV;
            addr_d  = req_row_s;
            bank_d  = req_bank_s;
            set_s   = 1'b1;
            cnt_d   = RCD_LD;
            state_d = ST_ACTV;
         end
         2'b01: begin
            cmd_d   = req_we_q ? CMD_WRTE : CMD_READ;
            addr_d  = rw_addr_s;
            bank_d  = req_bank_s;
            state_d = ST_IDLE;
         end
         default: begin
            set_s = set_s;
         end
      endcase
   end

   // State, pin registers, refresh ack, data-phase pulses and the accepted request.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         cnt_q      <= {CNT_W{1'b0}};
         cmd_q      <= CMD_NOOP;
         addr_q     <= {ROW_W{1'b0}};
         bank_q     <= {BANK_W{1'b0}};
         ack_q      <= 1'b0;
         wr_en_q    <= 1'b0;
         rd_pipe_q  <= {CAS_LATENCY{1'b0}};
         req_we_q   <= 1'b0;
         req_addr_q <= {AW{1'b0}};
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         cmd_q        <= cmd_d;
         addr_q       <= addr_d;
         bank_q       <= bank_d;
         ack_q        <= ack_d;
         wr_en_q      <= (cmd_q == CMD_WRTE);
         rd_pipe_q[0] <= (cmd_q == CMD_READ);
         for (int i = 1; i < CAS_LATENCY; i++) begin
            rd_pipe_q[i] <= rd_pipe_q[i-1];
         end
         if (req_valid_i && req_ready_o) begin
            req_we_q   <= req_we_i;
            req_addr_q <= req_addr_i;
         end
      end
   end

   assign cmd_o          = cmd_q;
   assign addr_o         = addr_q;
   assign bank_o         = bank_q;
   assign wr_en_o        = wr_en_q;
   assign rd_valid_o     = rd_pipe_q[CAS_LATENCY-1];
   assign any_row_open_o = any_open_s;

endmodule

// File: tb/tb_ddr_bank_sequencer.sv
// Scoreboard bench: a bank/timing model pushes expected commands and data pulses when a request
// or refresh is driven; a monitor pops and compares them as the DUT produces them.
module tb_ddr_bank_sequencer;

   localparam int T_RP  = 3;
   localparam int T_RCD = 3;
   localparam int T_RFC = 10;
   localparam int CL    = 3;
   localparam logic [2:0] C_NOOP = 3'b111, C_ACTV = 3'b011, C_READ = 3'b101,
                          C_WRTE = 3'b100, C_PRCH = 3'b010, C_ARSR = 3'b001;

   typedef struct {
      int          edge_n;
      logic [2:0]  cmd;
      logic [12:0] addr;
      logic [12:0] amask;
      logic [1:0]  bank;
      bit          chk_bank;
   } exp_cmd_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        strobe = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [24:0] req_addr = 25'd0;
   logic [2:0]  cmd;
   logic [12:0] addr;
   logic [1:0]  bank;
   logic        wr_en, rd_valid, any_open;

   int       cyc = 0;
   int       n_cmp = 0;
   int       n_bad = 0;
   exp_cmd_t cmd_exp[$];
   int       rd_exp[$];
   int       wr_exp[$];
   bit       m_open[4];
   logic [12:0] m_row[4];
   int       m_free = 0;
   int       last_acc = 0;
   int       last_arsr = 0;

   ddr_bank_sequencer dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .refresh_strobe_i (strobe),
      .req_valid_i      (req_valid),
      .req_ready_o      (req_ready),
      .req_we_i         (req_we),
      .req_addr_i       (req_addr),
      .cmd_o            (cmd),
      .addr_o           (addr),
      .bank_o           (bank),
      .wr_en_o          (wr_en),
      .rd_valid_o       (rd_valid),
      .any_row_open_o   (any_open)
   );

   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic push_cmd(input int e, input logic [2:0] c, input logic [12:0] a,
                           input logic [12:0] m, input logic [1:0] b, input bit cb);
      exp_cmd_t x;
      x.edge_n = e; x.cmd = c; x.addr = a; x.amask = m; x.bank = b; x.chk_bank = cb;
      cmd_exp.push_back(x);
   endtask

   // Monitor: sample 1 time unit after each rising edge, compare against the scoreboard.
   always @(posedge clk) begin : mon
      exp_cmd_t e;
      cyc = cyc + 1;
      #1;
      if (!rst) begin
         if (cmd !== C_NOOP) begin
            if (cmd_exp.size() == 0) begin
               check_value("unexpected_cmd", 32'(cmd), 32'(C_NOOP));
            end else begin
               e = cmd_exp.pop_front();
               check_value("cmd_code", 32'(cmd), 32'(e.cmd));
               check_value("cmd_cycle", cyc, e.edge_n);
               check_value("cmd_addr", 32'(addr & e.amask), 32'(e.addr & e.amask));
               if (e.chk_bank) check_value("cmd_bank", 32'(bank), 32'(e.bank));
            end
         end
         if (wr_en) begin
            if (wr_exp.size() == 0) check_value("unexpected_wr_en", 32'd1, 32'd0);
            else check_value("wr_en_cycle", cyc, wr_exp.pop_front());
         end
         if (rd_valid) begin
            if (rd_exp.size() == 0) check_value("unexpected_rd_valid", 32'd1, 32'd0);
            else check_value("rd_valid_cycle", cyc, rd_exp.pop_front());
         end
      end
   end

   task automatic drive_req(input bit we, input logic [12:0] r, input logic [1:0] b,
                            input logic [9:0] c);
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = {r, b, c};
   endtask

   // Waits for the handshake, checks its timing, and models the resulting command sequence.
   task automatic finish_req();
      int exp_acc, acc, e, rw, n;
      logic [12:0] r;
      logic [1:0]  b;
      logic [9:0]  c;
      exp_acc = (cyc + 1 > m_free) ? cyc + 1 : m_free;
      n = 0;
      while (!req_ready && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         check_value("accept_timeout", 32'd0, 32'd1);
         req_valid = 1'b0;
         return;
      end
      acc = cyc + 1;
      last_acc = acc;
      check_value("accept_edge", acc, exp_acc);
      r = req_addr[24:12];
      b = req_addr[11:10];
      c = req_addr[9:0];
      e = acc + 1;
      if (m_open[b] && m_row[b] == r) begin
         rw = e;
      end else if (!m_open[b]) begin
         push_cmd(e, C_ACTV, r, 13'h1FFF, b, 1'b1);
         rw = e + T_RCD;
      end else begin
         push_cmd(e, C_PRCH, 13'h000, 13'h0400, b, 1'b1);
         push_cmd(e + T_RP, C_ACTV, r, 13'h1FFF, b, 1'b1);
         rw = e + T_RP + T_RCD;
      end
      m_open[b] = 1'b1;
      m_row[b]  = r;
      push_cmd(rw, req_we ? C_WRTE : C_READ, {3'b000, c}, 13'h1FFF, b, 1'b1);
      if (req_we) wr_exp.push_back(rw + 1);
      else rd_exp.push_back(rw + CL);
      m_free = rw + 1;
      @(posedge clk);
      #2 req_valid = 1'b0;
   endtask

   task automatic service_refresh();
      int er, arsr;
      bit any;
      er  = (cyc + 1 > m_free) ? cyc + 1 : m_free;
      any = m_open[0] | m_open[1] | m_open[2] | m_open[3];
      if (any) push_cmd(er, C_PRCH, 13'h0400, 13'h1FFF, 2'd0, 1'b0);
      arsr = any ? er + T_RP : er;
      push_cmd(arsr, C_ARSR, 13'h0000, 13'h0000, 2'd0, 1'b0);
      for (int i = 0; i < 4; i++) m_open[i] = 1'b0;
      m_free    = arsr + T_RFC + 1;
      last_arsr = arsr;
   endtask

   task automatic wait_idle();
      while (cyc + 1 < m_free) @(negedge clk);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 4; i++) begin
         m_open[i] = 1'b0;
         m_row[i]  = 13'd0;
      end
      repeat (2) @(negedge clk);
      check_value("rst_cmd", 32'(cmd), 32'(C_NOOP));
      check_value("rst_addr", 32'(addr), 32'd0);
      check_value("rst_bank", 32'(bank), 32'd0);
      check_value("rst_wr_en", 32'(wr_en), 32'd0);
      check_value("rst_rd_valid", 32'(rd_valid), 32'd0);
      check_value("rst_any_open", 32'(any_open), 32'd0);
      check_value("rst_req_ready", 32'(req_ready), 32'd0);
      rst = 1'b0;
      m_free = cyc + 1;

      // Closed bank read, hit write, then a row miss in the same bank.
      drive_req(1'b0, 13'd1, 2'd2, 10'd5);  finish_req();
      drive_req(1'b1, 13'd1, 2'd2, 10'd9);  finish_req();
      drive_req(1'b1, 13'd7, 2'd2, 10'd3);  finish_req();
      // Second bank plus back-to-back hits; top column value.
      drive_req(1'b0, 13'h1FFF, 2'd0, 10'h3FF); finish_req();
      drive_req(1'b0, 13'h1FFF, 2'd0, 10'd1);   finish_req();
      drive_req(1'b1, 13'h1FFF, 2'd0, 10'd2);   finish_req();
      wait_idle();
      check_value("any_open_after_actv", 32'(any_open), 32'd1);

      // Refresh toggle in the same cycle as a request: refresh wins.
      wait_idle();
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = {13'd7, 2'd2, 10'd4};
      strobe    = ~strobe;
      #1 check_value("ready_refresh_block", 32'(req_ready), 32'd0);
      service_refresh();
      while (cyc < last_arsr + 1) @(negedge clk);
      check_value("any_open_after_ref", 32'(any_open), 32'd0);
      check_value("ready_during_rfc", 32'(req_ready), 32'd0);
      finish_req();

      // Even toggle count during tRFC coalesces; one more toggle gives exactly one refresh.
      wait_idle();
      @(negedge clk);
      strobe = ~strobe;
      service_refresh();
      while (cyc < last_arsr + 2) @(negedge clk);
      strobe = ~strobe;
      @(negedge clk);
      @(negedge clk);
      strobe = ~strobe;
      while (cyc < m_free + 6) @(negedge clk);
      check_value("no_extra_refresh", cmd_exp.size(), 32'd0);
      check_value("ready_after_coalesce", 32'(req_ready), 32'd1);
      @(negedge clk);
      strobe = ~strobe;
      service_refresh();

      // Reset in the middle of the tRCD wait abandons the sequence.
      wait_idle();
      drive_req(1'b0, 13'd9, 2'd1, 10'd2); finish_req();
      while (cyc < last_acc + 2) @(negedge clk);
      rst    = 1'b1;
      strobe = 1'b0;
      #1;
      check_value("rst_mid_cmd", 32'(cmd), 32'(C_NOOP));
      check_value("rst_mid_any_open", 32'(any_open), 32'd0);
      cmd_exp.delete();
      rd_exp.delete();
      wr_exp.delete();
      for (int i = 0; i < 4; i++) m_open[i] = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      m_free = cyc + 1;
      drive_req(1'b0, 13'd9, 2'd1, 10'd2); finish_req();
      drive_req(1'b1, 13'd9, 2'd1, 10'd6); finish_req();

      repeat (20) @(negedge clk);
      check_value("cmd_queue_drained", cmd_exp.size(), 32'd0);
      check_value("rd_queue_drained", rd_exp.size(), 32'd0);
      check_value("wr_queue_drained", wr_exp.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
